cdc_stream_loopback: RTL
========================

Name: cdc_stream_loopback

Overview:
Parametrised application-side loopback engine for the USB CDC bulk byte streams. Accepts bytes from the CDC OUT stream, applies a selectable per-byte transform in one registered stage, buffers them in a DEPTH-entry FIFO and returns them on the CDC IN stream. Adds runtime mode selection, an IN hold (host-visible NAKs), flush, fill level and traffic counters. Sits between u_usb_cdc and the SoC top.

Parameters:
DEPTH, 16, FIFO entries; power of 2, range 2..256
CNT_W, 16, width of the rx/tx byte counters

Ports:
clk_i  in  1  application clock (same clock as the CDC app interface)
rst_i  in  1  synchronous reset, active-high
mode_i  in  2  transform select, sampled per accepted byte
hold_i  in  1  1 = suppress in_valid_o (forces IN NAKs)
clear_i  in  1  synchronous flush of stage and FIFO
out_data_i  in  8  byte from CDC OUT endpoint
out_valid_i  in  1  out_data_i valid
out_ready_o  out  1  block can accept out_data_i
in_data_o  out  8  byte to CDC IN endpoint
in_valid_o  out  1  in_data_o valid
in_ready_i  in  1  CDC IN endpoint takes in_data_o
level_o  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH (stage register excluded)
rx_count_o  out  CNT_W  accepted OUT bytes, wraps
tx_count_o  out  CNT_W  delivered IN bytes, wraps

Behaviour:
- Reset (rst_i=1 at a clock edge): stage empty, FIFO pointers 0, counters 0. All outputs 0 while rst_i=1, including out_ready_o (forced 0 combinationally by rst_i). Reset mid-transfer discards all buffered bytes.
- Input handshake: byte accepted when out_valid_i & out_ready_o. out_ready_o = ~rst_i & (~s_valid | ~full). No combinational path from out_valid_i to out_ready_o.
- Transform stage: on accept, s_data <= f(out_data_i, mode_i), s_valid <= 1. mode_i changes affect only bytes accepted afterwards.
  - 00: echo unchanged.
  - 01: 'A'..'Z' +0x20. '0'..'8' +1. '9' -> '0'. Others unchanged.
  - 10: 'a'..'z' -0x20. Others unchanged.
  - 11: bitwise invert.
- Stage -> FIFO: write when s_valid & ~full. Full is evaluated at cycle start; a pop in the same cycle does not enable a write. s_valid clears on write unless a new byte is accepted in the same cycle.
- Latency: byte accepted at edge N; stage holds it after N; written at edge N+1; in_valid_o high in the cycle after N+1 (2 cycles, FIFO empty, hold_i=0).
- Output: FIFO is show-ahead. in_data_o = entry at read pointer. in_valid_o = ~empty & ~hold_i. Pop on in_valid_o & in_ready_i. in_data_o reads 0 when empty.
- hold_i only gates in_valid_o. Input and buffering continue until full, then out_ready_o drops (host sees OUT NAK).
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and LSBs equal. level_o = wr_ptr - rd_ptr. Simultaneous write and pop with FIFO neither empty nor full leaves level_o unchanged.
- Ordering is strict FIFO; no byte is lost or duplicated under any ready/valid pattern.
- clear_i (rst_i=0): s_valid <= 0 and rd_ptr <= wr_ptr. clear_i overrides accept and pop in the same cycle; out_ready_o and in_valid_o are 0 while clear_i=1. Counters are not affected.
- Counters: rx_count_o increments per accept, tx_count_o per pop, modulo 2^CNT_W. Both can increment in the same cycle.

Test Plan:
- Mode 00: send 01..07 -> IN returns 01..07. in_valid_o rises 2 cycles after the first accept. rx_count=tx_count=7, level_o=0 at end.
- Mode 01: send "ABCDEFGH12345678" -> IN returns "abcdefgh23456789". Then send "9z" -> returns "0z".
- Fill with hold_i=1, DEPTH=16, send 20 bytes -> 17 accepted (16 in FIFO, 1 in stage). out_ready_o=0, level_o=16. Release hold_i -> all 20 delivered in order.
- Simultaneous push/pop at level_o=5 with in_ready_i=1 throughout -> level_o stays 5 across 100 bytes. No gaps or duplicates.
- Pointer wrap: stream 3*DEPTH+3 bytes with random valid/ready throttling, mode 11 -> every output equals ~input, in order. Counters match the byte count.
- Reset and clear mid-stream: with 6 bytes buffered, pulse clear_i -> level_o=0, in_valid_o=0, counters unchanged. Pulse rst_i -> counters 0 and out_ready_o=0 during reset.

Source files
------------

// File: rtl/cdc_stream_loopback.sv
// -----------------------------------------------------------------------------
// cdc_stream_loopback
//
// Application-side loopback engine for the USB CDC bulk byte streams. Bytes
// arriving on the CDC OUT stream pass through a one-stage registered per-byte
// transform. They are then buffered in a DEPTH-entry show-ahead FIFO and
// returned on the CDC IN stream. The block also provides runtime mode
// selection, an IN hold, a flush, the FIFO fill level and traffic counters.
//
// Parameters:
//   DEPTH       FIFO entries (power of 2, 2..256)
//   CNT_W       width of the rx/tx byte counters
//
// Ports:
//   clk_i       application clock (same clock as the CDC app interface)
//   rst_i       synchronous reset, active-high; every output reads 0 while high
//   mode_i      transform select, sampled with each accepted byte
//                 00 echo, 01 to-lower + digit rotate, 10 to-upper, 11 invert
//   hold_i      1 = suppress in_valid_o, so the host sees IN NAKs
//   clear_i     synchronous flush of the transform stage and the FIFO
//   out_data_i  byte from the CDC OUT endpoint
//   out_valid_i out_data_i valid
//   out_ready_o block can accept out_data_i
//   in_data_o   byte to the CDC IN endpoint (entry at the read pointer)
//   in_valid_o  in_data_o valid
//   in_ready_i  CDC IN endpoint takes in_data_o
//   level_o     FIFO occupancy 0..DEPTH (the stage register is not counted)
//   rx_count_o  accepted OUT bytes, wraps
//   tx_count_o  delivered IN bytes, wraps
// -----------------------------------------------------------------------------
module cdc_stream_loopback #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic                     hold_i,
  input  logic                     clear_i,
  input  logic [7:0]               out_data_i,
  input  logic                     out_valid_i,
  output logic                     out_ready_o,
  output logic [7:0]               in_data_o,
  output logic                     in_valid_o,
  input  logic                     in_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         rx_count_o,
  output logic [CNT_W-1:0]         tx_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    MODE_ECHO   = 2'b00,
    MODE_LOWER  = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;

  // Per-byte transform applied while the byte is captured into the stage.
  // MODE_LOWER also rotates the digits: '0'..'8' step up by one and '9'
  // wraps around to '0'.
  function automatic logic [7:0] transform(input logic [7:0] b, input logic [1:0] m);
    logic [7:0] r;
    r = b;
    case (mode_e'(m))
      MODE_LOWER: begin
        if (b >= 8'h41 && b <= 8'h5A)      r = b + 8'h20;
        else if (b >= 8'h30 && b <= 8'h38) r = b + 8'h01;
        else if (b == 8'h39)               r = 8'h30;
      end
      MODE_UPPER: begin
        if (b >= 8'h61 && b <= 8'h7A)      r = b - 8'h20;
      end
      MODE_INVERT: r = ~b;
      default:     r = b;
    endcase
    return r;
  endfunction

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [7:0]       s_data;
  logic             s_valid;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] tx_cnt;

  logic             empty;
  logic             full;
  logic             accept;
  logic             write;
  logic             pop;

  // The pointers carry one extra wrap bit. Equal pointers mean empty. Pointers
  // whose wrap bits differ but whose index bits are equal mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready depends only on registered state, rst_i and clear_i, and never on
  // out_valid_i. The stage can take a new byte when it is empty, or when it
  // will drain into a FIFO that is not full in this same cycle.
  assign out_ready_o = ~rst_i & ~clear_i & (~s_valid | ~full);
  assign accept      = out_valid_i & out_ready_o;

  // Full is taken from the cycle-start state, so a pop in the same cycle
  // cannot open a slot for the stage. A flush cancels the stage write.
  assign write       = s_valid & ~full & ~clear_i & ~rst_i;

  // hold_i only hides the IN side. Buffering continues behind it.
  assign in_valid_o  = ~rst_i & ~clear_i & ~hold_i & ~empty;
  assign pop         = in_valid_o & in_ready_i;

  assign in_data_o   = (rst_i | empty) ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign level_o     = rst_i ? '0 : (wr_ptr - rd_ptr);
  assign rx_count_o  = rst_i ? '0 : rx_cnt;
  assign tx_count_o  = rst_i ? '0 : tx_cnt;

  // Control state: stage occupancy, FIFO pointers and counters.
  // A flush drops the stage and moves the read pointer onto the write
  // pointer, which throws away everything buffered. The counters keep their
  // values through a flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_valid <= 1'b0;
      s_data  <= 8'h00;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rx_cnt  <= '0;
      tx_cnt  <= '0;
    end else begin
      if (clear_i)     s_valid <= 1'b0;
      else if (accept) s_valid <= 1'b1;
      else if (write)  s_valid <= 1'b0;

      if (accept) s_data <= transform(out_data_i, mode_i);

      if (write) wr_ptr <= wr_ptr + PW'(1);

      if (clear_i)  rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);

      if (accept) rx_cnt <= rx_cnt + CNT_W'(1);
      if (pop)    tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  // FIFO storage. It has no reset, because entries outside the window
  // between the pointers are never observed.
  always_ff @(posedge clk_i) begin
    if (write) mem[wr_ptr[AW-1:0]] <= s_data;
  end

endmodule
